// File: rtl/fifo_read_streamer_pkg.sv
// Shared definitions for the FIFO read streamer: FSM state encoding and skid sizing.
// Used by fifo_read_streamer and fifo_read_skid (FIFO_READ_STREAMER_STATS_EN is consumed by the top only).
package fifo_read_streamer_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } stream_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_read_skid.sv
// Two-entry in-order skid buffer holding words captured from the FIFO until the stream accepts them.
// Callers guarantee no push when full and no pop when empty; clear wins over push/pop.
module fifo_read_skid
    import fifo_read_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [OCC_WIDTH-1:0]  occupancy,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
            head_q    <= '0;
            tail_q    <= '0;
        end else if (clear) begin
            occupancy <= '0;
        end else if (push && !pop) begin
            if (occupancy == '0) begin
                head_q <= push_data;
            end else begin
                tail_q <= push_data;
            end
            occupancy <= occupancy + 1'b1;
        end else if (!push && pop) begin
            head_q    <= tail_q;
            occupancy <= occupancy - 1'b1;
        end else if (push && pop) begin
            // Simultaneous push and pop keeps occupancy; the new word lands behind any survivor.
            if (occupancy == OCC_WIDTH'(SKID_DEPTH)) begin
                head_q <= tail_q;
                tail_q <= push_data;
            end else begin
                head_q <= push_data;
            end
        end
    end

    assign head_data = head_q;

endmodule

// File: rtl/fifo_read_streamer.sv
// Turns a FIFO read port (pop, data one cycle later) into a valid/ready stream, with a discard-drain flush.
// Define FIFO_READ_STREAMER_STATS_EN to add the word_count delivered-word counter port.
module fifo_read_streamer
    import fifo_read_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  read_clk,
    input  logic                  read_reset,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    output logic                  flush_busy
`ifdef FIFO_READ_STREAMER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] word_count
`endif
);

    stream_state_t        state;
    stream_state_t        next_state;
    logic                 inflight;
    logic [OCC_WIDTH-1:0] occupancy;
    logic                 pop_accepted;
    logic                 handshake;
    logic                 capture;
    logic                 clear_buf;

    assign pop_accepted = fifo_read_en && !fifo_empty;
    assign out_valid    = (occupancy != '0);
    assign handshake    = out_valid && out_ready;
    assign capture      = inflight && (state == RUN);
    assign clear_buf    = (state == RUN) && flush;

    always_ff @(posedge read_clk or posedge read_reset) begin
        if (read_reset) begin
            state    <= RUN;
            inflight <= 1'b0;
        end else begin
            state    <= next_state;
            inflight <= pop_accepted;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (flush) next_state = FLUSH;
            FLUSH:   if (fifo_empty && !inflight) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Pop only when the word can be guaranteed a skid slot; gated by reset so nothing is requested while held.
    always_comb begin
        fifo_read_en = 1'b0;
        flush_busy   = 1'b0;
        if (!read_reset) begin
            case (state)
                RUN: fifo_read_en = !fifo_empty &&
                    ((int'(occupancy) + int'(inflight) - int'(handshake)) < SKID_DEPTH);
                FLUSH: begin
                    fifo_read_en = !fifo_empty;
                    flush_busy   = 1'b1;
                end
                default: fifo_read_en = 1'b0;
            endcase
        end
    end

    fifo_read_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (read_clk),
        .rst       (read_reset),
        .push      (capture),
        .push_data (fifo_read_data),
        .pop       (handshake),
        .clear     (clear_buf),
        .occupancy (occupancy),
        .head_data (out_data)
    );

`ifdef FIFO_READ_STREAMER_STATS_EN
    always_ff @(posedge read_clk or posedge read_reset) begin
        if (read_reset) begin
            word_count <= '0;
        end else if (handshake) begin
            word_count <= word_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Self-checking bench for fifo_read_streamer: FIFO model, stream scoreboard, vector table and corner sequences.
// Build with FIFO_READ_STREAMER_STATS_EN defined to also exercise word_count (STAT_WIDTH=4).
module tb_fifo_read_streamer;

    logic       read_clk = 1'b0;
    logic       read_reset;
    logic       fifo_empty;
    logic       fifo_read_en;
    logic [7:0] fifo_read_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
    logic       flush_busy;
`ifdef FIFO_READ_STREAMER_STATS_EN
    logic [3:0] word_count;
`endif

    logic [7:0] fifo_q[$];
    logic [7:0] sb_q[$];
    int  checks    = 0;
    int  failures  = 0;
    int  pop_count = 0;
    int  delivered = 0;
    bit  toggle_mode  = 1'b0;
    bit  toggle_phase = 1'b0;

    always #5 read_clk = ~read_clk;

    fifo_read_streamer #(
        .DATA_WIDTH(8),
        .STAT_WIDTH(4)
    ) dut (
        .read_clk       (read_clk),
        .read_reset     (read_reset),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .flush          (flush),
        .flush_busy     (flush_busy)
`ifdef FIFO_READ_STREAMER_STATS_EN
        ,
        .word_count     (word_count)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic flush_pulse);
        @(posedge read_clk);
        #1;
        out_ready = ready;
        flush     = flush_pulse;
    endtask

    task automatic writeWord(input logic [7:0] d);
        fifo_q.push_back(d);
        sb_q.push_back(d);
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n = 0;
        while ((sb_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            @(posedge read_clk);
            #1;
            n++;
        end
        checkOutput({name, "_drained"}, sb_q.size(), 0);
    endtask

    task automatic waitFlushDone(input int budget);
        int n = 0;
        while (flush_busy && n < budget) begin
            @(posedge read_clk);
            #1;
            n++;
        end
        checkOutput("flush_busy_falls", flush_busy, 1'b0);
    endtask

    // FIFO model: pop on an accepted request, data appears one edge later; empty flag refreshed mid-cycle.
    always @(posedge read_clk) begin
        if (fifo_empty === 1'b1) checkOutput("read_en_while_empty", fifo_read_en, 1'b0);
        if (!read_reset && fifo_read_en && !fifo_empty && fifo_q.size() > 0) begin
            fifo_read_data <= fifo_q.pop_front();
            pop_count++;
        end
    end

    always @(negedge read_clk) begin
        if (toggle_mode) toggle_phase = ~toggle_phase;
        fifo_empty = (fifo_q.size() == 0) || (toggle_mode && toggle_phase);
    end

    always @(posedge read_clk) begin
        if (!read_reset && out_valid && out_ready) begin
            delivered++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word: got %0h, expected no word", out_data);
            end else begin
                checkOutput("stream_order", out_data, sb_q.pop_front());
            end
        end
    end

    typedef struct {
        bit         push_burst;
        logic       exp_read_en;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   p0;
        int   d0;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h44};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h88};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'hCC};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00};

        read_reset     = 1'b1;
        out_ready      = 1'b0;
        flush          = 1'b0;
        fifo_empty     = 1'b1;
        fifo_read_data = 8'h00;
        #12;
        checkOutput("reset_read_en", fifo_read_en, 1'b0);
        checkOutput("reset_valid", out_valid, 1'b0);
        checkOutput("reset_data", out_data, 8'h00);
        checkOutput("reset_flush_busy", flush_busy, 1'b0);
`ifdef FIFO_READ_STREAMER_STATS_EN
        checkOutput("reset_word_count", word_count, 4'd0);
`endif
        @(posedge read_clk);
        #1;
        read_reset = 1'b0;

        $display("[TB] burst of four words with out_ready high");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (vecs[i].push_burst) begin
                writeWord(8'h00);
                writeWord(8'h44);
                writeWord(8'h88);
                writeWord(8'hCC);
            end
            #7;
            checkOutput($sformatf("burst_read_en_%0d", i), fifo_read_en, vecs[i].exp_read_en);
            checkOutput($sformatf("burst_valid_%0d", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) checkOutput($sformatf("burst_data_%0d", i), out_data, vecs[i].exp_data);
        end

        $display("[TB] backpressure with out_ready low");
        applyStimulus(1'b0, 1'b0);
        p0 = pop_count;
        writeWord(8'h00);
        writeWord(8'h10);
        writeWord(8'h20);
        writeWord(8'h30);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0);
            #7;
            if (i >= 2) begin
                checkOutput("bp_valid_held", out_valid, 1'b1);
                checkOutput("bp_data_held", out_data, 8'h00);
            end
        end
        checkOutput("bp_pop_count", pop_count - p0, 2);
        checkOutput("bp_read_en_low", fifo_read_en, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitDrain(40, "bp");

        $display("[TB] fifo_empty toggling every cycle");
        toggle_mode = 1'b1;
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) writeWord(8'h5A + 8'(i));
        waitDrain(60, "toggle");
        toggle_mode = 1'b0;

        $display("[TB] flush with buffered words and a non-empty FIFO");
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) writeWord(8'h70 + 8'(i));
        repeat (6) applyStimulus(1'b0, 1'b0);
        #7;
        checkOutput("pre_flush_valid", out_valid, 1'b1);
        p0 = pop_count;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        sb_q.delete();
        checkOutput("flush_valid_dropped", out_valid, 1'b0);
        checkOutput("flush_busy_high", flush_busy, 1'b1);
        waitFlushDone(30);
        checkOutput("flush_pops_discarded", pop_count - p0, 5);
        checkOutput("flush_fifo_empty", fifo_empty, 1'b1);
        d0 = delivered;
        applyStimulus(1'b1, 1'b0);
        writeWord(8'hA5);
        waitDrain(20, "post_flush");
        checkOutput("post_flush_delivered", delivered - d0, 1);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) writeWord(8'h30 + 8'(i));
        repeat (3) applyStimulus(1'b1, 1'b0);
        #2;
        read_reset = 1'b1;
        fifo_q.delete();
        sb_q.delete();
        #1;
        checkOutput("midreset_read_en", fifo_read_en, 1'b0);
        checkOutput("midreset_valid", out_valid, 1'b0);
        checkOutput("midreset_data", out_data, 8'h00);
        checkOutput("midreset_flush_busy", flush_busy, 1'b0);
`ifdef FIFO_READ_STREAMER_STATS_EN
        checkOutput("midreset_word_count", word_count, 4'd0);
`endif
        @(posedge read_clk);
        #3;
        read_reset = 1'b0;
        d0 = delivered;
        writeWord(8'h11);
        writeWord(8'h22);
        waitDrain(20, "post_reset");
        checkOutput("post_reset_delivered", delivered - d0, 2);

`ifdef FIFO_READ_STREAMER_STATS_EN
        $display("[TB] word counter wrap and flush immunity");
        checkOutput("stats_after_reset_seq", word_count, 4'd2);
        applyStimulus(1'b1, 1'b0);
        read_reset = 1'b1;
        #1;
        read_reset = 1'b0;
        for (int i = 0; i < 17; i++) writeWord(8'(i * 3));
        waitDrain(60, "stats");
        repeat (2) applyStimulus(1'b1, 1'b0);
        checkOutput("stats_wrap", word_count, 4'd1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitFlushDone(10);
        checkOutput("stats_flush_unchanged", word_count, 4'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
